dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter and access sequencer in front of the byte-addressed data memory: 4096 bytes, write on posedge, read on negedge. It shares the single memory port between the core load/store path (port 0) and a loader/DMA path (port 1) using round-robin arbitration. It registers the granted request onto the memory port and captures the read data. It returns a one-cycle acknowledge with the data to the requester.

## Interface
- `ADDR_W`, 32 — address width on request and memory ports.
- `DM_BYTES`, 4096 — memory size in bytes; used only by the range check (see Configuration).
- `clk` in 1 — single clock; all state changes on rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `p0_req` / `p1_req` in 1 — request valid; held stable with its fields until the matching ack.
- `p0_we` / `p1_we` in 1 — 1 means store, 0 means load.
- `p0_addr` / `p1_addr` in ADDR_W — byte address.
- `p0_wdata` / `p1_wdata` in 32 — store data; bytes are taken from the LSBs.
- `p0_ctrl` / `p1_ctrl` in 3 — access size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- `p0_ack` / `p1_ack` out 1 — one-cycle completion pulse.
- `p0_rdata` / `p1_rdata` out 32 — load result; valid while the matching ack is high.
- `p0_err` / `p1_err` out 1 — access rejected; valid with ack. Tied 0 without the macro.
- `dm_addr` out ADDR_W, `dm_wdata` out 32, `dm_ctrl` out 3, `dm_wr_en` out 1 — drive the memory port.
- `dm_rdata` in 32 — memory read data; updated by the memory on the falling edge.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port that was not granted last. `last_gnt` resets to 1, so port 0 wins the first tie.
  - On grant: latch addr, wdata, ctrl and we into the `dm_*` registers, update `last_gnt`, go to ACCESS.
- ACCESS:
  - `dm_wr_en` = latched we for exactly this cycle.
  - At the closing edge: capture `dm_rdata` into the granted port's rdata register, go to RESP.
- RESP:
  - Granted port's ack = 1; `dm_wr_en` = 0; go to IDLE.
  - Requests are not sampled in RESP.
- rdata registers hold their value between accesses. Stores also capture `dm_rdata`, so rdata after a store is don't-care.
- `dm_ctrl` values 100 and 101 with we = 1 are passed through unchanged; the memory performs no write for them.
- Each requester needs the arbiter only for ordering. The arbiter keeps one access in flight and never reorders.

## Timing
- A request seen high in cycle N with the FSM in IDLE:
  - Memory is driven in cycle N+1.
  - A write commits at the end of cycle N+1.
  - Ack and rdata appear in cycle N+2.
  - The FSM is back in IDLE in cycle N+3.
- Throughput is one access per 3 cycles. With both ports requesting continuously, grants alternate 0,1,0,1.
- The requester samples ack at the end of cycle N+2. It may drop req or present a new request from cycle N+3.
- Reset values: state IDLE, `last_gnt` 1, `dm_wr_en` 0, `dm_addr` 0, `dm_wdata` 0, `dm_ctrl` 000, all ack 0, all err 0, all rdata 0.
- Reset asserted during ACCESS forces `dm_wr_en` low immediately (asynchronously). The in-flight write is dropped unless the rising edge has already occurred. No ack is issued for it.
- A req that drops before ack is a requester protocol violation; the latched access still completes and acks.

## Configuration
- Macro: `DM_ARB_ACCESS_CHECK_EN`.
- Defined: in IDLE, each granted request is checked for three faults:
  - misalignment: half with addr[0] = 1, or word with addr[1:0] ≠ 00;
  - out of range: addr + size > `DM_BYTES`;
  - illegal ctrl: 011, 110 or 111.
- A faulting request skips ACCESS and goes directly to RESP: ack = 1, err = 1, rdata unchanged, `dm_wr_en` never asserted. Latency is 2 cycles.
- Not defined: no checks, err tied to 0, every grant goes through ACCESS.

## Structure
- Package `dm_pkg`:
  - ctrl code localparams `DM_BYTE`, `DM_HALF`, `DM_WORD`, `DM_BYTEU`, `DM_HALFU`;
  - FSM state typedef `dm_arb_state_t`;
  - size-from-ctrl function, shared with the load/store decode.
- One sub-module, `dm_rr_pick`: combinational 2-way round-robin picker (inputs req[1:0] and last; outputs gnt_valid and gnt_idx).
- Optional checker logic lives inline under the macro.

## Test plan
- Port 0 word store: 0xDEADBEEF to 0x10, then word load from 0x10 → `dm_wr_en` high only in cycle N+1; p0_ack in N+2; load rdata 0xDEADBEEF.
- Port 1 signed byte load of 0x80 at 0x21, then unsigned byte load of the same byte → rdata 0xFFFFFF80, then 0x00000080.
- Both ports requesting continuously for 6 accesses → grant order 0,1,0,1,0,1; no ack on both ports in the same cycle.
- Reset pulse during ACCESS of a store of 0x55 to 0x30 → `dm_wr_en` drops at once; no ack; FSM in IDLE; byte at 0x30 unchanged.
- With `DM_ARB_ACCESS_CHECK_EN`, word load at 0x13 → ack + err in cycle N+1, no memory write, rdata unchanged. Without the macro, the same request → normal 3-cycle access, err 0.
- Port 0 half store 0xA5B6 to 0x40, then port 1 signed half load from 0x40 → rdata 0xFFFFA5B6.

Source files
------------

// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory access path.
//   - access size codes carried on the ctrl fields (DM_BYTE .. DM_HALFU)
//   - arbiter FSM state type dm_arb_state_t
//   - dm_size(): byte count for a ctrl code, also used by load/store decode
// -----------------------------------------------------------------------------
package dm_pkg;

  localparam logic [2:0] DM_BYTE  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_WORD  = 3'b010;
  localparam logic [2:0] DM_BYTEU = 3'b100;
  localparam logic [2:0] DM_HALFU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_arb_state_t;

  // Number of bytes touched by an access; 0 marks an illegal ctrl code.
  function automatic logic [2:0] dm_size(input logic [2:0] ctrl);
    case (ctrl)
      DM_BYTE, DM_BYTEU: dm_size = 3'd1;
      DM_HALF, DM_HALFU: dm_size = 3'd2;
      DM_WORD:           dm_size = 3'd4;
      default:           dm_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// -----------------------------------------------------------------------------
// dm_rr_pick
// Combinational two-way round-robin picker.
//   req[1:0]  in  - request valid per port
//   last      in  - port granted most recently
//   gnt_valid out - at least one request present
//   gnt_idx   out - chosen port; on a tie the port that did not win last time
// -----------------------------------------------------------------------------
module dm_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Round-robin arbiter and access sequencer sharing the single data-memory port
// between the core load/store path (port 0) and the loader/DMA path (port 1).
// One access in flight: IDLE (grant + latch) -> ACCESS (memory driven, read
// data captured at the closing edge) -> RESP (one-cycle ack) -> IDLE.
//
// Optional feature macro: DM_ARB_ACCESS_CHECK_EN
//   When defined, each granted request is checked for misalignment, range
//   overflow against DM_BYTES and illegal ctrl codes; a faulting request skips
//   ACCESS and is acked with err=1. When undefined, err is tied to 0.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   pN_req/we/addr/wdata/ctrl      request from port N (held until ack)
//   pN_ack, pN_rdata, pN_err       one-cycle completion, load data, reject
//   dm_addr/wdata/ctrl/wr_en       registered memory port
//   dm_rdata                       memory read data (updated on falling edge)
// -----------------------------------------------------------------------------
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [2:0]        p0_ctrl,
  output logic              p0_ack,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [2:0]        p1_ctrl,
  output logic              p1_ack,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,

  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [2:0]        dm_ctrl,
  output logic              dm_wr_en,
  input  logic [31:0]       dm_rdata
);

  dm_arb_state_t     state;
  logic              last_gnt;
  logic              gnt_q;     // port owning the in-flight access
  logic [1:0]        ack_q;
  logic [1:0]        err_q;

  logic              pick_valid;
  logic              pick_idx;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_ctrl;
  logic              sel_fault;

  dm_rr_pick u_pick (
    .req       ({p1_req, p0_req}),
    .last      (last_gnt),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // Fields of the port the picker chose this cycle.
  assign sel_we    = pick_idx ? p1_we    : p0_we;
  assign sel_addr  = pick_idx ? p1_addr  : p0_addr;
  assign sel_wdata = pick_idx ? p1_wdata : p0_wdata;
  assign sel_ctrl  = pick_idx ? p1_ctrl  : p0_ctrl;

`ifdef DM_ARB_ACCESS_CHECK_EN
  logic [2:0]      sel_size;
  logic            f_misalign;
  logic            f_range;
  logic            f_ctrl;
  logic [ADDR_W:0] sel_end;   // one extra bit so addr + size cannot wrap

  assign sel_size   = dm_size(sel_ctrl);
  assign f_ctrl     = (sel_size == 3'd0);
  assign f_misalign = ((sel_size == 3'd2) && sel_addr[0]) ||
                      ((sel_size == 3'd4) && (sel_addr[1:0] != 2'b00));
  assign sel_end    = {1'b0, sel_addr} + (ADDR_W+1)'(sel_size);
  assign f_range    = sel_end > (ADDR_W+1)'(DM_BYTES);
  assign sel_fault  = f_misalign | f_range | f_ctrl;

  assign p0_err = err_q[0];
  assign p1_err = err_q[1];
`else
  assign sel_fault = 1'b0;
  assign p0_err    = 1'b0;
  assign p1_err    = 1'b0;
`endif

  assign p0_ack = ack_q[0];
  assign p1_ack = ack_q[1];

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples values from before the edge, independent of statement
  // order; the asynchronous reset also clears the rdata holding registers so
  // the outputs are defined from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;
      gnt_q    <= 1'b0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_ctrl  <= 3'b000;
      dm_wr_en <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            dm_addr  <= sel_addr;
            dm_wdata <= sel_wdata;
            dm_ctrl  <= sel_ctrl;
            last_gnt <= pick_idx;
            gnt_q    <= pick_idx;
            if (sel_fault) begin
              // Rejected access: straight to the response, memory untouched.
              ack_q[pick_idx] <= 1'b1;
              err_q[pick_idx] <= 1'b1;
              state           <= ST_RESP;
            end else begin
              dm_wr_en <= sel_we;
              state    <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          // The memory presented dm_rdata on the falling edge of this cycle.
          if (gnt_q) p1_rdata <= dm_rdata;
          else       p0_rdata <= dm_rdata;
          dm_wr_en     <= 1'b0;
          ack_q[gnt_q] <= 1'b1;
          state        <= ST_RESP;
        end

        ST_RESP: begin
          ack_q <= 2'b00;
          err_q <= 2'b00;
          state <= ST_IDLE;
        end

        default: begin
          dm_wr_en <= 1'b0;
          ack_q    <= 2'b00;
          err_q    <= 2'b00;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Directed bench for dm_arbiter with a byte-addressed 4 KiB memory model
// (write on rising edge, read with size/sign handling on falling edge).
// Compile with +define+DM_ARB_ACCESS_CHECK_EN to exercise the access checker.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dm_arbiter;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        p0_req = 0, p0_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0;
  logic [2:0]  p0_ctrl = 0;
  logic        p0_ack, p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req = 0, p1_we = 0;
  logic [31:0] p1_addr = 0, p1_wdata = 0;
  logic [2:0]  p1_ctrl = 0;
  logic        p1_ack, p1_err;
  logic [31:0] p1_rdata;

  logic [31:0] dm_addr, dm_wdata;
  logic [2:0]  dm_ctrl;
  logic        dm_wr_en;
  logic [31:0] dm_rdata = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(32), .DM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ctrl(p0_ctrl), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ctrl(p1_ctrl), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ctrl(dm_ctrl),
    .dm_wr_en(dm_wr_en), .dm_rdata(dm_rdata)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [0:4095];
  logic       mem_clear = 1'b1;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (dm_wr_en) begin
      case (dm_ctrl)
        3'b000: mem[dm_addr[11:0]] <= dm_wdata[7:0];
        3'b001: begin
          mem[dm_addr[11:0]]         <= dm_wdata[7:0];
          mem[dm_addr[11:0] + 12'd1] <= dm_wdata[15:8];
        end
        3'b010: begin
          mem[dm_addr[11:0]]         <= dm_wdata[7:0];
          mem[dm_addr[11:0] + 12'd1] <= dm_wdata[15:8];
          mem[dm_addr[11:0] + 12'd2] <= dm_wdata[23:16];
          mem[dm_addr[11:0] + 12'd3] <= dm_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[dm_addr[11:0]];
    b1 = mem[dm_addr[11:0] + 12'd1];
    b2 = mem[dm_addr[11:0] + 12'd2];
    b3 = mem[dm_addr[11:0] + 12'd3];
    case (dm_ctrl)
      3'b000:  dm_rdata <= {{24{b0[7]}}, b0};
      3'b100:  dm_rdata <= {24'h0, b0};
      3'b001:  dm_rdata <= {{16{b1[7]}}, b1, b0};
      3'b101:  dm_rdata <= {16'h0, b1, b0};
      default: dm_rdata <= {b3, b2, b1, b0};
    endcase
  end

  // ---------------- helpers ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One request on one port; reports the ack latency in cycles counted from
  // cycle N (1 = ack in N, 3 = ack in N+2), the dm_wr_en value in each cycle
  // (bit c = cycle N+c), dm_addr in cycle N+1 and whether the other port acked.
  // lat = 0 means no ack within the budget.
  task automatic do_access(input bit port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] ctrl,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output logic [7:0] wr_mask,
                           output logic [31:0] addr_n1, output logic other_ack);
    bit done;
    @(posedge clk); #1;
    if (port == 1'b0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_ctrl = ctrl; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_ctrl = ctrl; p1_req = 1'b1;
    end
    lat = 0; wr_mask = '0; other_ack = 1'b0; done = 1'b0;
    rdata = 'x; err = 1'bx; addr_n1 = 'x;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      wr_mask[c] = dm_wr_en;
      if (c == 1) addr_n1 = dm_addr;
      if ((port ? p0_ack : p1_ack) === 1'b1) other_ack = 1'b1;
      if ((port ? p1_ack : p0_ack) === 1'b1) begin
        lat   = c + 1;
        rdata = port ? p1_rdata : p0_rdata;
        err   = port ? p1_err : p0_err;
        done  = 1'b1;
      end
    end
    @(posedge clk); #1;
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (dm_wr_en !== 1'b0)   begin errors++; $display("FAIL reset_wr_en got=%b exp=0", dm_wr_en); end
    checks++; if (dm_addr !== 32'h0)   begin errors++; $display("FAIL reset_addr got=%h exp=0", dm_addr); end
    checks++; if (dm_wdata !== 32'h0)  begin errors++; $display("FAIL reset_wdata got=%h exp=0", dm_wdata); end
    checks++; if (dm_ctrl !== 3'b000)  begin errors++; $display("FAIL reset_ctrl got=%b exp=000", dm_ctrl); end
    checks++; if ({p1_ack, p0_ack} !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", {p1_ack, p0_ack}); end
    checks++; if ({p1_err, p0_err} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {p1_err, p0_err}); end
    checks++; if (p0_rdata !== 32'h0)  begin errors++; $display("FAIL reset_p0_rdata got=%h exp=0", p0_rdata); end
    checks++; if (p1_rdata !== 32'h0)  begin errors++; $display("FAIL reset_p1_rdata got=%h exp=0", p1_rdata); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state); end
    rst_n = 1'b1;
    mem_clear = 1'b0;
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd, a1; logic er, oth; int lat; logic [7:0] wm;
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, DM_WORD, rd, er, lat, wm, a1, oth);
    checks++; if (lat !== 3)        begin errors++; $display("FAIL st_word_latency got=%0d exp=3", lat); end
    checks++; if (wm !== 8'b010)    begin errors++; $display("FAIL st_word_wr_en got=%b exp=010", wm); end
    checks++; if (a1 !== 32'h10)    begin errors++; $display("FAIL st_word_dm_addr got=%h exp=10", a1); end
    checks++; if (er !== 1'b0)      begin errors++; $display("FAIL st_word_err got=%b exp=0", er); end
    checks++; if (oth !== 1'b0)     begin errors++; $display("FAIL st_word_other_ack got=%b exp=0", oth); end
    checks++; if ({mem[19], mem[18], mem[17], mem[16]} !== 32'hDEADBEEF)
      begin errors++; $display("FAIL st_word_mem got=%h exp=deadbeef", {mem[19], mem[18], mem[17], mem[16]}); end
    do_access(1'b0, 1'b0, 32'h10, 32'h0, DM_WORD, rd, er, lat, wm, a1, oth);
    checks++; if (lat !== 3)        begin errors++; $display("FAIL ld_word_latency got=%0d exp=3", lat); end
    checks++; if (wm !== 8'b000)    begin errors++; $display("FAIL ld_word_wr_en got=%b exp=000", wm); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_rdata got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_sign();
    logic [31:0] rd, a1; logic er, oth; int lat; logic [7:0] wm;
    do_access(1'b1, 1'b1, 32'h21, 32'h12345680, DM_BYTE, rd, er, lat, wm, a1, oth);
    checks++; if (mem[33] !== 8'h80) begin errors++; $display("FAIL st_byte_mem got=%h exp=80", mem[33]); end
    checks++; if ({mem[34], mem[32]} !== 16'h0000) begin errors++; $display("FAIL st_byte_neighbors got=%h exp=0000", {mem[34], mem[32]}); end
    do_access(1'b1, 1'b0, 32'h21, 32'h0, DM_BYTE, rd, er, lat, wm, a1, oth);
    checks++; if (lat !== 3)            begin errors++; $display("FAIL ld_byte_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_signed got=%h exp=ffffff80", rd); end
    checks++; if (oth !== 1'b0)         begin errors++; $display("FAIL ld_byte_other_ack got=%b exp=0", oth); end
    do_access(1'b1, 1'b0, 32'h21, 32'h0, DM_BYTEU, rd, er, lat, wm, a1, oth);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL ld_byte_unsigned got=%h exp=00000080", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd, a1; logic er, oth; int lat; logic [7:0] wm;
    do_access(1'b0, 1'b1, 32'h40, 32'h0000A5B6, DM_HALF, rd, er, lat, wm, a1, oth);
    checks++; if (wm !== 8'b010)   begin errors++; $display("FAIL st_half_wr_en got=%b exp=010", wm); end
    do_access(1'b1, 1'b0, 32'h40, 32'h0, DM_HALF, rd, er, lat, wm, a1, oth);
    checks++; if (rd !== 32'hFFFFA5B6) begin errors++; $display("FAIL ld_half_signed got=%h exp=ffffa5b6", rd); end
  endtask

  task automatic test_round_robin();
    logic [5:0] order;
    int n;
    logic both;
    apply_reset();
    @(posedge clk); #1;
    p0_we = 1'b0; p0_addr = 32'h10; p0_ctrl = DM_WORD; p0_req = 1'b1;
    p1_we = 1'b0; p1_addr = 32'h21; p1_ctrl = DM_BYTE; p1_req = 1'b1;
    n = 0; both = 1'b0; order = '0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (p0_ack === 1'b1 && p1_ack === 1'b1) both = 1'b1;
      if (p0_ack === 1'b1 || p1_ack === 1'b1) begin
        order[n] = p1_ack;
        n++;
      end
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    checks++; if (n !== 6)    begin errors++; $display("FAIL rr_ack_count got=%0d exp=6", n); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL rr_dual_ack got=%b exp=0", both); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (order[i] !== i[0]) begin errors++; $display("FAIL rr_grant_%0d got=%b exp=%b", i, order[i], i[0]); end
    end
    checks++; if (p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_p0_rdata got=%h exp=deadbeef", p0_rdata); end
    checks++; if (p1_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL rr_p1_rdata got=%h exp=ffffff80", p1_rdata); end
  endtask

  task automatic test_reset_in_access();
    logic [31:0] rd, a1; logic er, oth; int lat; logic [7:0] wm;
    logic ack_seen, wr_seen;
    do_access(1'b0, 1'b1, 32'h30, 32'h11, DM_BYTE, rd, er, lat, wm, a1, oth);
    checks++; if (mem[48] !== 8'h11) begin errors++; $display("FAIL rst_preload_mem got=%h exp=11", mem[48]); end
    @(posedge clk); #1;
    p0_we = 1'b1; p0_addr = 32'h30; p0_wdata = 32'h55; p0_ctrl = DM_BYTE; p0_req = 1'b1;
    @(posedge clk); #2;
    checks++; if (dm_wr_en !== 1'b1) begin errors++; $display("FAIL rst_access_wr_en got=%b exp=1", dm_wr_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (dm_wr_en !== 1'b0) begin errors++; $display("FAIL rst_async_wr_en got=%b exp=0", dm_wr_en); end
    p0_req = 1'b0;
    ack_seen = 1'b0; wr_seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (p0_ack !== 1'b0 || p1_ack !== 1'b0) ack_seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (p0_ack !== 1'b0 || p1_ack !== 1'b0) ack_seen = 1'b1;
      if (dm_wr_en !== 1'b0) wr_seen = 1'b1;
    end
    checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL rst_no_ack got=%b exp=0", ack_seen); end
    checks++; if (wr_seen !== 1'b0)  begin errors++; $display("FAIL rst_no_wr_en got=%b exp=0", wr_seen); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=IDLE", dut.state); end
    checks++; if (mem[48] !== 8'h11) begin errors++; $display("FAIL rst_mem_unchanged got=%h exp=11", mem[48]); end
  endtask

  task automatic test_access_check();
    logic [31:0] rd, a1; logic er, oth; int lat; logic [7:0] wm;
    do_access(1'b0, 1'b0, 32'h10, 32'h0, DM_WORD, rd, er, lat, wm, a1, oth);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL chk_setup_rdata got=%h exp=deadbeef", rd); end
`ifdef DM_ARB_ACCESS_CHECK_EN
    do_access(1'b0, 1'b0, 32'h13, 32'h0, DM_WORD, rd, er, lat, wm, a1, oth);
    checks++; if (lat !== 2)         begin errors++; $display("FAIL chk_misalign_latency got=%0d exp=2", lat); end
    checks++; if (er !== 1'b1)       begin errors++; $display("FAIL chk_misalign_err got=%b exp=1", er); end
    checks++; if (wm !== 8'b00)      begin errors++; $display("FAIL chk_misalign_wr_en got=%b exp=00", wm); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL chk_misalign_rdata got=%h exp=deadbeef", rd); end
    do_access(1'b1, 1'b1, 32'h1000, 32'h77, DM_BYTE, rd, er, lat, wm, a1, oth);
    checks++; if (er !== 1'b1 || lat !== 2) begin errors++; $display("FAIL chk_range got err=%b lat=%0d exp err=1 lat=2", er, lat); end
    checks++; if (wm !== 8'b00)      begin errors++; $display("FAIL chk_range_wr_en got=%b exp=00", wm); end
    do_access(1'b0, 1'b0, 32'hFFC, 32'h0, DM_WORD, rd, er, lat, wm, a1, oth);
    checks++; if (er !== 1'b0 || lat !== 3) begin errors++; $display("FAIL chk_top_word got err=%b lat=%0d exp err=0 lat=3", er, lat); end
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat, wm, a1, oth);
    checks++; if (er !== 1'b1 || lat !== 2) begin errors++; $display("FAIL chk_ctrl got err=%b lat=%0d exp err=1 lat=2", er, lat); end
`else
    do_access(1'b0, 1'b0, 32'h13, 32'h0, DM_WORD, rd, er, lat, wm, a1, oth);
    checks++; if (lat !== 3)         begin errors++; $display("FAIL nochk_latency got=%0d exp=3", lat); end
    checks++; if (er !== 1'b0)       begin errors++; $display("FAIL nochk_err got=%b exp=0", er); end
    checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL nochk_rdata got=%h exp=000000de", rd); end
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_word_store_load();
    test_byte_sign();
    test_half();
    test_round_robin();
    test_reset_in_access();
    test_access_check();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
